// File: rtl/p251_pkg.sv
// Shared constants, FSM state type and the 2^8-fold helper for the GF(251)
// datapath blocks.
package p251_pkg;

    // Field modulus and the folding constant 2^8 mod 251.
    localparam int unsigned Q       = 251;
    localparam logic [15:0] FOLD8   = 16'd5;
    // Largest value a single fold of a 17-bit sum can produce: 511*5 + 255.
    localparam int unsigned ACC_MAX = 2810;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_EMIT  = 3'd3,
        ST_WAIT  = 3'd4,
        ST_DONE  = 3'd5
    } p251_state_e;

    // s[16:8]*2^8 + s[7:0] is congruent to s[16:8]*5 + s[7:0] mod 251.
    function automatic logic [15:0] p251_fold(input logic [16:0] s);
        return ({7'd0, s[16:8]} * FOLD8) + {8'd0, s[7:0]};
    endfunction

endpackage

// File: rtl/p251_fold17.sv
// Combinational partial reduction of a 17-bit value to at most 2810,
// preserving the residue mod 251.
module p251_fold17
    import p251_pkg::*;
(
    input  logic [16:0] i_s,
    output logic [15:0] o_f
);

    // Single fold step; the result always fits in 12 bits.
    always_comb begin
        o_f = p251_fold(i_s);
    end

endmodule

// File: rtl/p251_dot_acc.sv
// Streaming GF(251) dot-product front end. Multiplies accepted operand
// pairs, keeps a partially reduced running sum, then hands it to the
// downstream reducer and returns the canonical result.
module p251_dot_acc
    import p251_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [LEN_W-1:0] i_len,
    input  logic             i_valid,
    input  logic [7:0]       i_a,
    input  logic [7:0]       i_b,
    output logic             o_ready,
    output logic             o_red_start,
    output logic [15:0]      o_red_a,
    input  logic             i_red_done,
    input  logic [7:0]       i_red_c,
    output logic [7:0]       o_c,
    output logic             o_done,
    output logic             o_busy
);

    localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

    p251_state_e      state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [15:0]      acc_q, acc_d;
    logic [15:0]      prod_q, prod_d;
    logic             pv_q, pv_d;
    logic [7:0]       c_q, c_d;

    logic [16:0]      sum_s;
    logic [15:0]      sum_fold;

    // Accumulate stage: acc + product never exceeds 17 bits because acc
    // stays at or below 2810 after every fold.
    assign sum_s = {1'b0, acc_q} + {1'b0, prod_q};

    p251_fold17 u_fold (
        .i_s (sum_s),
        .o_f (sum_fold)
    );

    // Next-state, multiply stage and accumulate stage.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        prod_d  = prod_q;
        pv_d    = 1'b0;
        c_d     = c_q;

        // The product registered last cycle folds in regardless of state;
        // this is what lets DRAIN absorb the final pair.
        if (pv_q) begin
            acc_d = sum_fold;
        end

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    len_d = i_len;
                    acc_d = '0;
                    cnt_d = '0;
                    pv_d  = 1'b0;
                    if (i_len == '0) begin
                        state_d = ST_EMIT;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (i_valid) begin
                    prod_d = {8'd0, i_a} * {8'd0, i_b};
                    pv_d   = 1'b1;
                    cnt_d  = cnt_q + LEN_ONE;
                    if (cnt_q == len_q - LEN_ONE) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                state_d = ST_EMIT;
            end
            ST_EMIT: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_red_done) begin
                    c_d     = i_red_c;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            prod_q  <= '0;
            pv_q    <= 1'b0;
            c_q     <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            prod_q  <= prod_d;
            pv_q    <= pv_d;
            c_q     <= c_d;
        end
    end

    // Handshake outputs depend on registered state only.
    assign o_ready     = (state_q == ST_RUN);
    assign o_red_start = (state_q == ST_EMIT);
    assign o_done      = (state_q == ST_DONE);
    assign o_busy      = (state_q != ST_IDLE);
    assign o_red_a     = acc_q;
    assign o_c         = c_q;

endmodule

// File: tb/tb_p251_dot_acc.sv
// Bench for p251_dot_acc: directed and random dot products checked against
// a sum-of-products mod 251 reference, with a behavioural reducer attached.
module tb_p251_dot_acc;

    localparam int LEN_W = 8;

    logic             i_clk;
    logic             i_rst;
    logic             i_start;
    logic [LEN_W-1:0] i_len;
    logic             i_valid;
    logic [7:0]       i_a;
    logic [7:0]       i_b;
    logic             o_ready;
    logic             o_red_start;
    logic [15:0]      o_red_a;
    logic             i_red_done;
    logic [7:0]       i_red_c;
    logic [7:0]       o_c;
    logic             o_done;
    logic             o_busy;

    int n_checks = 0;
    int n_errors = 0;

    p251_dot_acc #(.LEN_W(LEN_W)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_start     (i_start),
        .i_len       (i_len),
        .i_valid     (i_valid),
        .i_a         (i_a),
        .i_b         (i_b),
        .o_ready     (o_ready),
        .o_red_start (o_red_start),
        .o_red_a     (o_red_a),
        .i_red_done  (i_red_done),
        .i_red_c     (i_red_c),
        .o_c         (o_c),
        .o_done      (o_done),
        .o_busy      (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Behavioural reducer: done two cycles after start, c = a mod 251.
    logic [1:0]  red_pipe;
    logic [15:0] red_a_hold;
    always @(posedge i_clk) begin
        if (i_rst) begin
            red_pipe   <= 2'b00;
            red_a_hold <= 16'd0;
        end else begin
            red_pipe <= {red_pipe[0], o_red_start};
            if (o_red_start) red_a_hold <= o_red_a;
        end
    end
    assign i_red_done = red_pipe[1];
    assign i_red_c    = red_pipe[1] ? 8'(red_a_hold % 16'd251) : 8'hAA;

    // Cycle counter and output monitor.
    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int red_start_cnt = 0;
    int done_cnt      = 0;
    int start_cyc     = 0;
    int red_done_cyc  = 0;
    int done_cyc      = 0;
    int red_a_seen    = 0;
    int c_seen        = 0;
    int max_red_a     = 0;
    always @(negedge i_clk) begin
        if (o_red_start) begin
            red_start_cnt = red_start_cnt + 1;
            start_cyc     = cyc;
            red_a_seen    = int'(o_red_a);
        end
        if (i_red_done) red_done_cyc = cyc;
        if (o_done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
            c_seen   = int'(o_c);
        end
        if (int'(o_red_a) > max_red_a) max_red_a = int'(o_red_a);
    end

    int op_a [256];
    int op_b [256];

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Runs one operation; exp_red_a < 0 means only the residue of the
    // handed-off accumulator is checked. gap_mode: 0 none, 1 one idle
    // cycle after each pair, 2 random 0..2 idle cycles.
    task automatic run_op(input string tag, input int len, input int gap_mode,
                          input int exp_red_a, input bit dbl_start);
        longint sum;
        int exp_c;
        int s0, d0;
        int acc_cyc;
        int waited;
        int gap;
        bit timeout;
        sum = 0;
        for (int i = 0; i < len; i++) sum += longint'(op_a[i] * op_b[i]);
        exp_c   = int'(sum % 251);
        s0      = red_start_cnt;
        d0      = done_cnt;
        timeout = 1'b0;
        max_red_a = 0;

        @(negedge i_clk);
        i_start = 1'b1;
        i_len   = LEN_W'(len);
        acc_cyc = cyc;
        @(negedge i_clk);
        i_start = 1'b0;
        i_len   = LEN_W'($urandom_range(0, 255));

        for (int i = 0; i < len && !timeout; i++) begin
            i_valid = 1'b1;
            i_a     = 8'(op_a[i]);
            i_b     = 8'(op_b[i]);
            waited  = 0;
            while (!o_ready && waited < 20) begin
                @(negedge i_clk);
                waited++;
            end
            if (!o_ready) begin
                check({tag, "_ready_timeout"}, 0, 1);
                timeout = 1'b1;
            end else begin
                acc_cyc = cyc;
                @(negedge i_clk);
                if (gap_mode != 0 && i != len - 1) begin
                    gap = (gap_mode == 1) ? 1 : int'($urandom_range(0, 2));
                    i_valid = 1'b0;
                    i_a     = 8'($urandom_range(0, 255));
                    i_b     = 8'($urandom_range(0, 255));
                    repeat (gap) @(negedge i_clk);
                end
            end
        end
        i_valid = 1'b0;
        if (len > 0) check({tag, "_ready_low"}, int'(o_ready), 0);

        if (dbl_start) begin
            @(negedge i_clk);
            i_start = 1'b1;
            i_len   = LEN_W'(0);
            @(negedge i_clk);
            i_start = 1'b0;
        end

        waited = 0;
        while (done_cnt == d0 && waited < 100) begin
            @(negedge i_clk);
            waited++;
        end
        repeat (4) @(negedge i_clk);

        check({tag, "_start_cnt"}, red_start_cnt - s0, 1);
        check({tag, "_done_cnt"}, done_cnt - d0, 1);
        check({tag, "_start_lat"}, start_cyc - acc_cyc, (len == 0) ? 1 : 2);
        check({tag, "_done_lat"}, done_cyc - red_done_cyc, 1);
        if (exp_red_a >= 0) check({tag, "_red_a"}, red_a_seen, exp_red_a);
        check({tag, "_red_a_mod"}, red_a_seen % 251, exp_c);
        check({tag, "_acc_bound"}, int'(max_red_a <= 2810), 1);
        check({tag, "_c_pulse"}, c_seen, exp_c);
        check({tag, "_c_hold"}, int'(o_c), exp_c);
        check({tag, "_idle"}, int'(o_busy), 0);
        $display("op %s len=%0d red_a=%0d c=%0d expected_c=%0d", tag, len, red_a_seen, int'(o_c), exp_c);
    endtask

    initial begin
        int s0;
        int len;
        i_rst   = 1'b1;
        i_start = 1'b0;
        i_len   = '0;
        i_valid = 1'b0;
        i_a     = '0;
        i_b     = '0;
        repeat (3) @(negedge i_clk);
        check("rst_ready", int'(o_ready), 0);
        check("rst_busy", int'(o_busy), 0);
        check("rst_done", int'(o_done), 0);
        check("rst_red_start", int'(o_red_start), 0);
        check("rst_red_a", int'(o_red_a), 0);
        check("rst_c", int'(o_c), 0);
        i_rst = 1'b0;
        @(negedge i_clk);

        // Single worst-case pair.
        op_a[0] = 250; op_b[0] = 250;
        run_op("len1", 1, 0, 1256, 1'b0);

        // Three pairs, continuous and with gaps.
        op_a[0] = 1; op_b[0] = 2;
        op_a[1] = 3; op_b[1] = 4;
        op_a[2] = 5; op_b[2] = 6;
        run_op("len3", 3, 0, 44, 1'b0);
        run_op("len3_gap", 3, 1, 44, 1'b0);

        // Full-length vector of maximum operands.
        for (int i = 0; i < 255; i++) begin
            op_a[i] = 255;
            op_b[i] = 255;
        end
        run_op("len255", 255, 0, -1, 1'b0);

        // Empty vector, with a stray start while waiting on the reducer.
        run_op("len0", 0, 0, 0, 1'b1);

        // Reset in the middle of a run.
        for (int i = 0; i < 4; i++) begin
            op_a[i] = int'($urandom_range(1, 255));
            op_b[i] = int'($urandom_range(1, 255));
        end
        @(negedge i_clk);
        i_start = 1'b1;
        i_len   = LEN_W'(4);
        @(negedge i_clk);
        i_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            i_valid = 1'b1;
            i_a     = 8'(op_a[i]);
            i_b     = 8'(op_b[i]);
            @(negedge i_clk);
        end
        s0    = red_start_cnt;
        i_rst = 1'b1;
        @(negedge i_clk);
        check("mid_rst_ready", int'(o_ready), 0);
        check("mid_rst_busy", int'(o_busy), 0);
        check("mid_rst_red_start", int'(o_red_start), 0);
        check("mid_rst_red_a", int'(o_red_a), 0);
        check("mid_rst_c", int'(o_c), 0);
        check("mid_rst_done", int'(o_done), 0);
        i_rst   = 1'b0;
        i_valid = 1'b0;
        repeat (10) @(negedge i_clk);
        check("mid_rst_no_req", red_start_cnt - s0, 0);
        check("mid_rst_still_idle", int'(o_busy), 0);

        op_a[0] = 7;  op_b[0] = 9;
        op_a[1] = 10; op_b[1] = 10;
        run_op("after_rst", 2, 0, 163, 1'b0);

        // Random vectors with random valid gaps.
        for (int t = 0; t < 8; t++) begin
            len = int'($urandom_range(1, 40));
            for (int i = 0; i < len; i++) begin
                op_a[i] = int'($urandom_range(0, 255));
                op_b[i] = int'($urandom_range(0, 255));
            end
            run_op($sformatf("rand%0d", t), len, 2, -1, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
